flag_ctrl: RTL and testbench
============================

// Module: flag_ctrl
// PURPOSE
//  Multi-context condition-flag controller for the pipelined core. Holds one N/V/Z flag set per
//  hardware context and counts in-flight flag-setting instructions per context. Evaluates branch
//  conditions and stalls the issue stage until the flags a branch depends on are final.
//  Sits between decode/issue and the ALU writeback stage.
// PARAMETERS
//  NCTX   2   number of hardware contexts, each with its own flag set (>=1)
//  CTX_W  1   context-id width, $clog2(NCTX) with minimum 1
//  CNT_W  2   width of each pending-flag-write counter; max in flight = 2**CNT_W-1
// PORTS
//  clk          in   1      core clock
//  rst          in   1      synchronous, active-high reset
//  issue_valid  in   1      instruction offered by issue stage
//  issue_ctx    in   CTX_W  context of offered instruction
//  issue_instr  in   16     instruction; opcode [15:12], branch condition [10:8]
//  issue_ready  out  1      offered instruction accepted this cycle (0 = stall)
//  alu_valid    in   1      ALU writeback of flags this cycle
//  alu_ctx      in   CTX_W  context of writeback
//  alu_n/v/z    in   1 each flag values from ALU
//  br_valid     out  1      registered: branch resolved (1-cycle pulse)
//  br_ctx       out  CTX_W  context of resolved branch
//  br_taken     out  1      branch outcome
//  err          out  1      sticky: writeback arrived for a context with pending==0
// BEHAVIOUR
//  - Reset: all flags 0, all counters 0, br_valid/br_ctx/br_taken/err = 0. Inputs ignored while rst=1.
//  - Setters: ADD, SUB, NAND, XOR, INC. Accepted setter: pending[ctx]++.
//    Setter stalls (issue_ready=0) iff pending[ctx]==2**CNT_W-1.
//  - Writeback: alu_valid writes n/v/z into bank[alu_ctx] on the next edge and decrements pending[alu_ctx].
//    If pending is already 0: flags are still written, the counter holds at 0, and err is set.
//  - Simultaneous accepted setter and writeback on the same ctx: the counter is unchanged.
//  - Branch (opcode B): "resolvable" iff pending[ctx]==0 (see FLAG_FWD_EN).
//    - Resolvable: issue_ready=1. The next cycle br_valid=1, br_ctx=ctx, br_taken=cond(flags).
//    - Otherwise issue_ready=0 and the branch is re-evaluated every cycle.
//  - All other opcodes are always accepted and produce no output. issue_ready=1 when issue_valid=0.
//  - Conditions [10:8], per cond_code.h:
//    EQUAL z | NOT_EQUAL ~z | GREATER ~z&~n&~v | LESS n&~v | GREATER_OR_EQUAL ~n&~v
//    LESS_OR_EQUAL (n&~v)|z | OVERFLOW v | TRUE 1
//  - Latency: branch resolution 1 cycle after acceptance.
//  - Contexts are fully independent. A stall in ctx0 does not depend on ctx1 state.
//  - Reset mid-stall: the stall is dropped, counters clear, and no br_valid is produced for the dropped branch.
// CONFIGURATION
//  FLAG_FWD_EN defined:
//   - A branch is also resolvable when pending[ctx]==1 and alu_valid && alu_ctx==ctx in the same cycle.
//   - cond() then uses the alu_n/v/z inputs directly.
//  FLAG_FWD_EN undefined:
//   - The branch waits until the counter reads 0 (one extra stall cycle after the last writeback).
//  Flag storage and counters are identical in both builds.
// STRUCTURE
//  - flag_pkg holds: opcode constants (ADD, SUB, NAND, XOR, INC, B) re-exported from opcode.h,
//    the cond_code.h condition encodings, and a flags_t struct {n, v, z}.
//  - Sub-module flag_cond_eval: combinational (flags_t, cond[2:0]) -> taken. One instance, fed by a
//    forward mux or by bank[issue_ctx].
//  - Top level: flag banks, pending counters, stall logic, output registers.
// TESTING
//  1 Reset, then branch ctx0 cond TRUE -> issue_ready=1; next cycle br_valid=1, br_taken=1, br_ctx=0.
//  2 ADD ctx0, then branch EQUAL ctx0; writeback z=1 two cycles later.
//    Stall until resolved, then br_taken=1. Stall count is 2 with FLAG_FWD_EN, 3 without.
//  3 Issue 3 setters ctx1 with no writeback (CNT_W=2) -> a 4th setter ctx1 stalls.
//    A setter on ctx0 is still accepted the same cycle.
//  4 Writeback ctx0 n=1,v=0 then branch LESS ctx0 -> taken=1.
//    Same sequence with v=1 -> taken=0. Branch GREATER with n=v=z=0 -> taken=1.
//  5 alu_valid ctx1 with pending[1]==0 -> err=1 and stays 1; flags of ctx1 are updated.
//  6 Branch stalled on ctx0 (pending=1), assert rst 1 cycle -> no br_valid after reset; pending[0]=0.
//    Reissued branch resolves next cycle.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared definitions for the condition-flag controller: opcodes, condition codes and the flag set.
package flag_pkg;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
  } flags_t;

  // Opcode values mirrored from opcode.h.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_B    = 4'h5;

  // Condition encodings mirrored from cond_code.h.
  typedef enum logic [2:0] {
    COND_EQUAL            = 3'd0,
    COND_NOT_EQUAL        = 3'd1,
    COND_GREATER          = 3'd2,
    COND_LESS             = 3'd3,
    COND_GREATER_OR_EQUAL = 3'd4,
    COND_LESS_OR_EQUAL    = 3'd5,
    COND_OVERFLOW         = 3'd6,
    COND_TRUE             = 3'd7
  } cond_e;

  function automatic logic is_setter(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
           (op == OP_XOR) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational branch-condition evaluator: (flags, condition code) -> taken.
module flag_cond_eval
  import flag_pkg::*;
(
  input  flags_t     flags_i,
  input  logic [2:0] cond_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQUAL:            taken_o = flags_i.z;
      COND_NOT_EQUAL:        taken_o = ~flags_i.z;
      COND_GREATER:          taken_o = ~flags_i.z & ~flags_i.n & ~flags_i.v;
      COND_LESS:             taken_o = flags_i.n & ~flags_i.v;
      COND_GREATER_OR_EQUAL: taken_o = ~flags_i.n & ~flags_i.v;
      COND_LESS_OR_EQUAL:    taken_o = (flags_i.n & ~flags_i.v) | flags_i.z;
      COND_OVERFLOW:         taken_o = flags_i.v;
      COND_TRUE:             taken_o = 1'b1;
      default:               taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_ctrl.sv
// Multi-context N/V/Z flag controller with pending-write counters and branch stall/resolve.
// Optional FLAG_FWD_EN: a branch may resolve off the same-cycle ALU writeback of its last pending setter.
module flag_ctrl
  import flag_pkg::*;
#(
  parameter int NCTX  = 2,
  parameter int CTX_W = (NCTX > 1) ? $clog2(NCTX) : 1,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [CTX_W-1:0] issue_ctx,
  input  logic [15:0]      issue_instr,
  output logic             issue_ready,
  input  logic             alu_valid,
  input  logic [CTX_W-1:0] alu_ctx,
  input  logic             alu_n,
  input  logic             alu_v,
  input  logic             alu_z,
  output logic             br_valid,
  output logic [CTX_W-1:0] br_ctx,
  output logic             br_taken,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  flags_t           bank_q [NCTX];
  flags_t           bank_d [NCTX];
  logic [CNT_W-1:0] pend_q [NCTX];
  logic [CNT_W-1:0] pend_d [NCTX];
  logic             err_q, err_d;
  logic             br_valid_q;
  logic [CTX_W-1:0] br_ctx_q;
  logic             br_taken_q;

  logic [3:0]       opcode;
  logic             isSetter, isBranch;
  logic [CNT_W-1:0] curPend;
  logic             fwdHit, resolvable, acceptSetter, fire, taken;
  flags_t           evalFlags, aluFlags;
  logic             unusedInstrBits;

  assign opcode          = issue_instr[15:12];
  assign isSetter        = is_setter(opcode);
  assign isBranch        = (opcode == OP_B);
  assign aluFlags        = '{n: alu_n, v: alu_v, z: alu_z};
  assign unusedInstrBits = ^{issue_instr[11], issue_instr[7:0]};

  always_comb begin
    curPend = pend_q[issue_ctx];
    fwdHit  = 1'b0;
`ifdef FLAG_FWD_EN
    fwdHit  = alu_valid && (alu_ctx == issue_ctx) && (curPend == CNT_W'(1));
`else
    fwdHit  = 1'b0;
`endif
    resolvable = (curPend == '0) || fwdHit;
    evalFlags  = fwdHit ? aluFlags : bank_q[issue_ctx];

    issue_ready = 1'b1;
    if (issue_valid) begin
      if (isSetter)      issue_ready = (curPend != CNT_MAX);
      else if (isBranch) issue_ready = resolvable;
    end

    acceptSetter = issue_valid && isSetter && (curPend != CNT_MAX);
    fire         = issue_valid && isBranch && resolvable;
  end

  flag_cond_eval u_cond (
    .flags_i (evalFlags),
    .cond_i  (issue_instr[10:8]),
    .taken_o (taken)
  );

  // An increment and decrement on the same context cancel; a decrement at zero holds and flags err.
  always_comb begin
    err_d = err_q;
    for (int c = 0; c < NCTX; c++) begin
      bank_d[c] = bank_q[c];
      pend_d[c] = pend_q[c];
      if (alu_valid && (alu_ctx == CTX_W'(c))) begin
        bank_d[c] = aluFlags;
        if (pend_q[c] == '0) err_d = 1'b1;
        if (!(acceptSetter && (issue_ctx == CTX_W'(c))) && (pend_q[c] != '0))
          pend_d[c] = pend_q[c] - CNT_W'(1);
      end else if (acceptSetter && (issue_ctx == CTX_W'(c))) begin
        pend_d[c] = pend_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCTX; c++) begin
        bank_q[c] <= '0;
        pend_q[c] <= '0;
      end
      err_q      <= 1'b0;
      br_valid_q <= 1'b0;
      br_ctx_q   <= '0;
      br_taken_q <= 1'b0;
    end else begin
      for (int c = 0; c < NCTX; c++) begin
        bank_q[c] <= bank_d[c];
        pend_q[c] <= pend_d[c];
      end
      err_q      <= err_d;
      br_valid_q <= fire;
      if (fire) begin
        br_ctx_q   <= issue_ctx;
        br_taken_q <= taken;
      end
    end
  end

  assign br_valid = br_valid_q;
  assign br_ctx   = br_ctx_q;
  assign br_taken = br_taken_q;
  assign err      = err_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Scoreboard bench for flag_ctrl: stimulus pushes expected branch results, a negedge monitor pops them.
module tb_flag_ctrl;
  import flag_pkg::*;

  logic        clk, rst;
  logic        issue_valid, issue_ready;
  logic [0:0]  issue_ctx, alu_ctx, br_ctx;
  logic [15:0] issue_instr;
  logic        alu_valid, alu_n, alu_v, alu_z;
  logic        br_valid, br_taken, err;

  typedef struct packed {
    logic [0:0] ctx;
    logic       taken;
  } brExp_t;

  brExp_t expQ[$];
  brExp_t monExp;
  int     testsRun  = 0;
  int     failCount = 0;
  int     stalls;
  logic   gotReady;
  logic [3:0] setterOps [3] = '{OP_SUB, OP_NAND, OP_XOR};

`ifdef FLAG_FWD_EN
  localparam int EXP_STALLS = 2;
`else
  localparam int EXP_STALLS = 3;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  flag_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ctx   (issue_ctx),
    .issue_instr (issue_instr),
    .issue_ready (issue_ready),
    .alu_valid   (alu_valid),
    .alu_ctx     (alu_ctx),
    .alu_n       (alu_n),
    .alu_v       (alu_v),
    .alu_z       (alu_z),
    .br_valid    (br_valid),
    .br_ctx      (br_ctx),
    .br_taken    (br_taken),
    .err         (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] cond);
    return {op, 1'b0, cond, 8'h00};
  endfunction

  task automatic applyStimulus(input logic iv, input logic [0:0] ictx, input logic [15:0] instr,
                               input logic av, input logic [0:0] actx, input logic [2:0] nvz);
    issue_valid = iv;
    issue_ctx   = ictx;
    issue_instr = instr;
    alu_valid   = av;
    alu_ctx     = actx;
    {alu_n, alu_v, alu_z} = nvz;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectBr(input logic [0:0] c, input logic t);
    brExp_t e;
    e.ctx   = c;
    e.taken = t;
    expQ.push_back(e);
  endtask

  task automatic issueBranch(input logic [0:0] c, input logic [2:0] cond, input logic t);
    applyStimulus(1'b1, c, mk(OP_B, cond), 1'b0, 1'b0, 3'b000);
    #1;
    checkOutput("branch ready", {31'b0, issue_ready}, 1);
    expectBr(c, t);
    tick();
  endtask

  task automatic setterThenWb(input logic [0:0] c, input logic [2:0] nvz);
    applyStimulus(1'b1, c, mk(OP_ADD, 3'd0), 1'b0, 1'b0, 3'b000);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, c, nvz);
    tick();
  endtask

  // Every resolved branch must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (br_valid !== 1'b0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected br_valid", {31'b0, br_valid}, 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("br_ctx", {31'b0, br_ctx}, {31'b0, monExp.ctx});
        checkOutput("br_taken", {31'b0, br_taken}, {31'b0, monExp.taken});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    checkOutput("reset br_valid", {31'b0, br_valid}, 0);
    checkOutput("reset br_taken", {31'b0, br_taken}, 0);
    checkOutput("reset br_ctx", {31'b0, br_ctx}, 0);
    checkOutput("reset err", {31'b0, err}, 0);
    rst = 1'b0;

    // Unconditional branch right after reset
    issueBranch(1'b0, COND_TRUE, 1'b1);
    idle();
    tick();

    // Branch waiting on an in-flight ADD, writeback two cycles after the branch is offered
    applyStimulus(1'b1, 1'b0, mk(OP_ADD, 3'd0), 1'b0, 1'b0, 3'b000);
    #1;
    checkOutput("t2 add ready", {31'b0, issue_ready}, 1);
    tick();
    applyStimulus(1'b1, 1'b0, mk(OP_B, COND_EQUAL), 1'b0, 1'b0, 3'b000);
    stalls   = 0;
    gotReady = 1'b0;
    for (int k = 0; k < 10 && !gotReady; k++) begin
      alu_valid = (k == 2);
      alu_ctx   = 1'b0;
      {alu_n, alu_v, alu_z} = (k == 2) ? 3'b001 : 3'b000;
      #1;
      if (issue_ready) gotReady = 1'b1;
      else begin
        stalls++;
        tick();
      end
    end
    checkOutput("t2 stall count", stalls, EXP_STALLS);
    if (gotReady) expectBr(1'b0, 1'b1);
    tick();
    idle();

    // Fill ctx1 to its limit; ctx0 and non-setters are unaffected
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, mk(setterOps[i], 3'd0), 1'b0, 1'b0, 3'b000);
      #1;
      checkOutput("t3 setter ready", {31'b0, issue_ready}, 1);
      tick();
    end
    applyStimulus(1'b1, 1'b1, mk(OP_INC, 3'd0), 1'b0, 1'b0, 3'b000);
    #1;
    checkOutput("t3 full stall", {31'b0, issue_ready}, 0);
    tick();
    checkOutput("t3 full stall held", {31'b0, issue_ready}, 0);
    applyStimulus(1'b1, 1'b0, mk(OP_ADD, 3'd0), 1'b0, 1'b0, 3'b000);
    #1;
    checkOutput("t3 ctx0 setter ready", {31'b0, issue_ready}, 1);
    tick();
    applyStimulus(1'b1, 1'b1, mk(4'hE, 3'd0), 1'b0, 1'b0, 3'b000);
    #1;
    checkOutput("t3 other opcode ready", {31'b0, issue_ready}, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 3'b000);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 3'b000);
      tick();
    end
    idle();
    #1;
    checkOutput("t3 err after drain", {31'b0, err}, 0);
    tick();
    issueBranch(1'b1, COND_TRUE, 1'b1);

    // Condition evaluation over several flag patterns
    setterThenWb(1'b0, 3'b100);
    issueBranch(1'b0, COND_LESS, 1'b1);
    setterThenWb(1'b0, 3'b110);
    issueBranch(1'b0, COND_LESS, 1'b0);
    issueBranch(1'b0, COND_OVERFLOW, 1'b1);
    issueBranch(1'b0, COND_LESS_OR_EQUAL, 1'b0);
    setterThenWb(1'b0, 3'b000);
    issueBranch(1'b0, COND_GREATER, 1'b1);
    issueBranch(1'b0, COND_GREATER_OR_EQUAL, 1'b1);
    issueBranch(1'b1, COND_EQUAL, 1'b0);
    idle();
    #1;
    checkOutput("t4 err clear", {31'b0, err}, 0);
    tick();

    // Writeback with nothing pending: sticky err, flags still updated
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 3'b001);
    tick();
    idle();
    #1;
    checkOutput("t5 err set", {31'b0, err}, 1);
    tick();
    issueBranch(1'b1, COND_EQUAL, 1'b1);
    issueBranch(1'b1, COND_NOT_EQUAL, 1'b0);
    idle();
    tick();
    tick();
    checkOutput("t5 err sticky", {31'b0, err}, 1);

    // Reset while a branch is stalled
    applyStimulus(1'b1, 1'b0, mk(OP_ADD, 3'd0), 1'b0, 1'b0, 3'b000);
    tick();
    applyStimulus(1'b1, 1'b0, mk(OP_B, COND_TRUE), 1'b0, 1'b0, 3'b000);
    #1;
    checkOutput("t6 branch stalled", {31'b0, issue_ready}, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    checkOutput("t6 err cleared", {31'b0, err}, 0);
    checkOutput("t6 no br after reset", {31'b0, br_valid}, 0);
    tick();
    issueBranch(1'b0, COND_TRUE, 1'b1);
    idle();
    tick();
    tick();

    checkOutput("expected branches outstanding", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
